// File: rtl/msi_write_arbiter.sv
// Round-robin arbiter sharing one AXI-Lite MSI write master among NUM_REQ sources.
// Latches the granted address/data, pulses start, and tracks master busy for completion.
module msi_write_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int GAP_CYCLES     = 0
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NUM_REQ-1:0]                  req_valid_i,
  input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [NUM_REQ*AXI_DATA_WIDTH-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]                  req_ready_o,
  output logic [NUM_REQ-1:0]                  req_done_o,
  output logic                                wm_start_o,
  output logic [AXI_ADDR_WIDTH-1:0]           wm_addr_o,
  output logic [AXI_DATA_WIDTH-1:0]           wm_data_o,
  input  logic                                wm_busy_i,
  output logic                                arb_busy_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [IDX_W:0]   NREQ     = (IDX_W + 1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t                    state_q;
  logic [IDX_W-1:0]          rr_q;
  logic [IDX_W-1:0]          grant_q;
  logic [GAP_W-1:0]          gap_cnt_q;
  logic [NUM_REQ-1:0]        req_ready_q;
  logic [NUM_REQ-1:0]        req_done_q;
  logic                      wm_start_q;
  logic                      arb_busy_q;
  logic [AXI_ADDR_WIDTH-1:0] wm_addr_q;
  logic [AXI_DATA_WIDTH-1:0] wm_data_q;

  logic [AXI_ADDR_WIDTH-1:0] addr_slice [NUM_REQ];
  logic [AXI_DATA_WIDTH-1:0] data_slice [NUM_REQ];
  logic [NUM_REQ-1:0]        grant_oh;
  logic [NUM_REQ-1:0]        done_oh;
  logic [IDX_W-1:0]          grant_idx;
  logic [IDX_W:0]            cand;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign addr_slice[gi] = req_addr_i[gi*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
    assign data_slice[gi] = req_data_i[gi*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
    assign grant_oh[gi]   = (grant_idx == IDX_W'(gi));
    assign done_oh[gi]    = (grant_q == IDX_W'(gi));
  end

  // Scan offsets from the highest down so the nearest valid index after rr_q wins.
  always_comb begin
    grant_idx = '0;
    cand      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_q} + (IDX_W + 1)'(k);
      if (cand >= NREQ) cand = cand - NREQ;
      if (req_valid_i[cand[IDX_W-1:0]]) grant_idx = cand[IDX_W-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      rr_q        <= '0;
      grant_q     <= '0;
      gap_cnt_q   <= '0;
      req_ready_q <= '0;
      req_done_q  <= '0;
      wm_start_q  <= 1'b0;
      arb_busy_q  <= 1'b0;
      wm_addr_q   <= '0;
      wm_data_q   <= '0;
    end else begin
      req_ready_q <= '0;
      req_done_q  <= '0;
      wm_start_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if ((|req_valid_i) && !wm_busy_i) begin
            state_q     <= S_ISSUE;
            grant_q     <= grant_idx;
            wm_addr_q   <= addr_slice[grant_idx];
            wm_data_q   <= data_slice[grant_idx];
            wm_start_q  <= 1'b1;
            req_ready_q <= grant_oh;
            arb_busy_q  <= 1'b1;
          end
        end
        S_ISSUE: begin
          rr_q    <= (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;
          state_q <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (wm_busy_i) state_q <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (!wm_busy_i) begin
            req_done_q <= done_oh;
            gap_cnt_q  <= '0;
            if (GAP_CYCLES > 0) begin
              state_q <= S_GAP;
            end else begin
              state_q    <= S_IDLE;
              arb_busy_q <= 1'b0;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            state_q    <= S_IDLE;
            arb_busy_q <= 1'b0;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          arb_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o = req_ready_q;
  assign req_done_o  = req_done_q;
  assign wm_start_o  = wm_start_q;
  assign wm_addr_o   = wm_addr_q;
  assign wm_data_o   = wm_data_q;
  assign arb_busy_o  = arb_busy_q;

endmodule

// File: tb/tb_msi_write_arbiter.sv
// Directed bench for msi_write_arbiter: one instance with no gap, one with a 3-cycle gap,
// each driven by a simple write-master model that holds busy for a programmable length.
module tb_msi_write_arbiter;

  localparam int N  = 4;
  localparam int AW = 64;
  localparam int DW = 64;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N*AW-1:0] addr_bus;
  logic [N*DW-1:0] data_bus;

  logic [N-1:0]  valid0, ready0, done0;
  logic          start0, busy0, arb_busy0;
  logic [AW-1:0] wm_addr0;
  logic [DW-1:0] wm_data0;
  int            blen0, bcnt0;

  logic [N-1:0]  valid_g, ready_g, done_g;
  logic          start_g, busy_g, arb_busy_g;
  logic [AW-1:0] wm_addr_g;
  logic [DW-1:0] wm_data_g;
  int            blen_g, bcnt_g;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int start_cyc = 0;
  int d_cyc;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  msi_write_arbiter #(.NUM_REQ(N), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .GAP_CYCLES(0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(valid0), .req_addr_i(addr_bus),
    .req_data_i(data_bus), .req_ready_o(ready0), .req_done_o(done0), .wm_start_o(start0),
    .wm_addr_o(wm_addr0), .wm_data_o(wm_data0), .wm_busy_i(busy0), .arb_busy_o(arb_busy0)
  );

  msi_write_arbiter #(.NUM_REQ(N), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .GAP_CYCLES(3)) dut_gap (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(valid_g), .req_addr_i(addr_bus),
    .req_data_i(data_bus), .req_ready_o(ready_g), .req_done_o(done_g), .wm_start_o(start_g),
    .wm_addr_o(wm_addr_g), .wm_data_o(wm_data_g), .wm_busy_i(busy_g), .arb_busy_o(arb_busy_g)
  );

  // Write-master models: busy rises the cycle after start and stays high blen cycles.
  always @(posedge clk) begin
    if (!rst_n) begin
      busy0 <= 1'b0; bcnt0 <= 0;
    end else if (start0 && !busy0) begin
      busy0 <= 1'b1; bcnt0 <= blen0;
    end else if (busy0) begin
      if (bcnt0 == 1) busy0 <= 1'b0;
      bcnt0 <= bcnt0 - 1;
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      busy_g <= 1'b0; bcnt_g <= 0;
    end else if (start_g && !busy_g) begin
      busy_g <= 1'b1; bcnt_g <= blen_g;
    end else if (busy_g) begin
      if (bcnt_g == 1) busy_g <= 1'b0;
      bcnt_g <= bcnt_g - 1;
    end
  end

  function automatic logic [63:0] exp_addr(input int i);
    return 64'h2800_0000 + 64'(i) * 64'h2000;
  endfunction

  function automatic logic [63:0] exp_data(input int i);
    return 64'h11 + 64'(i) * 64'h2;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_start(input int k, input bit keep);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (start0) break;
    end
    chk("start_seen", 64'(start0), 64'd1);
    start_cyc = cyc;
    chk("ready_oh", 64'(ready0), 64'(4'b0001 << k));
    chk("wm_addr", wm_addr0, exp_addr(k));
    chk("wm_data", wm_data0, exp_data(k));
    chk("arb_busy_issue", 64'(arb_busy0), 64'd1);
    if (!keep) valid0[k] = 1'b0;
    @(negedge clk);
    chk("start_one_cycle", 64'(start0), 64'd0);
    chk("ready_one_cycle", 64'(ready0), 64'd0);
  endtask

  task automatic wait_done(input int k, input int blen);
    for (int i = 0; i < 40; i++) begin
      if (done0 != '0) break;
      chk("no_restart", 64'(start0), 64'd0);
      @(negedge clk);
    end
    chk("done_oh", 64'(done0), 64'(4'b0001 << k));
    chk("done_latency", 64'(cyc - start_cyc), 64'(blen + 2));
    chk("idle_at_done", 64'(arb_busy0), 64'd0);
    chk("addr_stable", wm_addr0, exp_addr(k));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    valid0  = '0;
    valid_g = '0;
    blen0   = 3;
    blen_g  = 2;
    for (int i = 0; i < N; i++) begin
      addr_bus[i*AW +: AW] = exp_addr(i);
      data_bus[i*DW +: DW] = exp_data(i);
    end

    // Reset values
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(ready0), 64'd0);
    chk("rst_done", 64'(done0), 64'd0);
    chk("rst_start", 64'(start0), 64'd0);
    chk("rst_arb_busy", 64'(arb_busy0), 64'd0);
    chk("rst_addr", wm_addr0, 64'd0);
    chk("rst_data", wm_data0, 64'd0);
    rst_n = 1'b1;

    // Single request from requester 2
    @(negedge clk);
    valid0 = 4'b0100;
    wait_start(2, 0);
    chk("single_addr_literal", wm_addr0, 64'h2800_4000);
    chk("single_data_literal", wm_data0, 64'h15);
    wait_done(2, 3);
    @(negedge clk);
    chk("done_one_cycle", 64'(done0), 64'd0);

    // Contention 0 and 3 from reset, then 0 and 1 after wrap
    do_reset();
    valid0 = 4'b1001;
    wait_start(0, 0);
    wait_done(0, 3);
    wait_start(3, 0);
    wait_done(3, 3);
    valid0 = 4'b0011;
    wait_start(0, 0);
    wait_done(0, 3);
    wait_start(1, 0);
    wait_done(1, 3);

    // Saturation: all four continuously valid
    do_reset();
    blen0  = 2;
    valid0 = 4'b1111;
    for (int t = 0; t < 8; t++) begin
      wait_start(t % 4, 1);
      wait_done(t % 4, 2);
      chk("sat_ready_onehot0", 64'($onehot0(ready0)), 64'd1);
      chk("sat_done_onehot", 64'($onehot(done0)), 64'd1);
    end
    valid0 = '0;

    // Reset while waiting for completion
    do_reset();
    blen0  = 6;
    valid0 = 4'b0001;
    wait_start(0, 0);
    @(negedge clk);
    chk("wait_done_busy", 64'(arb_busy0), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_ready", 64'(ready0), 64'd0);
    chk("midrst_done", 64'(done0), 64'd0);
    chk("midrst_start", 64'(start0), 64'd0);
    chk("midrst_arb_busy", 64'(arb_busy0), 64'd0);
    chk("midrst_addr", wm_addr0, 64'd0);
    chk("midrst_data", wm_data0, 64'd0);
    chk("midrst_rr", 64'(dut.rr_q), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("midrst_no_done", 64'(done0), 64'd0);
    end
    blen0  = 3;
    valid0 = 4'b0010;
    wait_start(1, 0);
    wait_done(1, 3);

    // Done-to-start interval without gap
    do_reset();
    blen0  = 2;
    valid0 = 4'b0011;
    wait_start(0, 0);
    wait_done(0, 2);
    d_cyc = cyc;
    wait_start(1, 0);
    chk("nogap_interval", 64'(start_cyc - d_cyc), 64'd1);
    wait_done(1, 2);

    // Withdrawn request from requester 1 during a transaction (rr_q now 2)
    blen0  = 5;
    valid0 = 4'b0001;
    wait_start(0, 0);
    valid0 = 4'b0010;
    @(negedge clk);
    valid0 = 4'b0000;
    wait_done(0, 5);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("withdrawn_no_start", 64'(start0), 64'd0);
      chk("withdrawn_no_ready", 64'(ready0), 64'd0);
    end

    // Gap instance: back-to-back requests 0 then 1
    valid_g = 4'b0011;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (start_g) break;
    end
    chk("gap_start0", 64'(start_g), 64'd1);
    chk("gap_ready0", 64'(ready_g), 64'b0001);
    valid_g[0] = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_g != '0) break;
    end
    chk("gap_done0", 64'(done_g), 64'b0001);
    chk("gap_busy_at_done", 64'(arb_busy_g), 64'd1);
    d_cyc = cyc;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (start_g) break;
    end
    chk("gap_start1", 64'(start_g), 64'd1);
    chk("gap_interval", 64'(cyc - d_cyc), 64'd4);
    chk("gap_ready1", 64'(ready_g), 64'b0010);
    chk("gap_addr1", wm_addr_g, exp_addr(1));
    valid_g = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_g != '0) break;
    end
    chk("gap_done1", 64'(done_g), 64'b0010);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
